// File: rtl/shift_reg_universal_n.sv
// Universal shift register with per-cycle hold/shift/load/rotate/arith modes
// and a counted burst engine that repeats one shift mode N times from a single start.
module shift_reg_universal_n #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [2:0]            mode,
    input  logic [DATA_WIDTH-1:0] p,
    input  logic                  SRSI,
    input  logic                  SLSI,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  shift_count,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  SRSO,
    output logic                  SLSO,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    state_t                  r_state;
    logic [2:0]              r_mode;
    logic [CNT_WIDTH-1:0]    r_remaining;
    logic [DATA_WIDTH-1:0]   r_q;
    logic                    r_busy;
    logic                    r_done;

    logic [2:0]              w_op_mode;
    logic [DATA_WIDTH-1:0]   w_next_q;
    logic                    w_is_shift;
    logic                    w_accept;
    logic [CNT_WIDTH-1:0]    w_count_m1;

    // While bursting the latched mode drives the datapath; inputs are ignored.
    assign w_op_mode = (r_state == S_BURST) ? r_mode : mode;

    always_comb begin
        w_next_q = r_q;
        unique case (w_op_mode)
            M_SHL:   w_next_q = {r_q[DATA_WIDTH-2:0], SRSI};
            M_SHR:   w_next_q = {SLSI, r_q[DATA_WIDTH-1:1]};
            M_LOAD:  w_next_q = p;
            M_ROL:   w_next_q = {r_q[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};
            M_ROR:   w_next_q = {r_q[0], r_q[DATA_WIDTH-1:1]};
            M_ASR:   w_next_q = {r_q[DATA_WIDTH-1], r_q[DATA_WIDTH-1:1]};
            default: w_next_q = r_q;
        endcase
    end

    always_comb begin
        w_is_shift = 1'b0;
        unique case (mode)
            M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: w_is_shift = 1'b1;
            default:                          w_is_shift = 1'b0;
        endcase
    end

    assign w_accept   = start && (r_state == S_IDLE) &&
                        (shift_count != '0) && w_is_shift;
    assign w_count_m1 = shift_count - CNT_WIDTH'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_mode      <= M_HOLD;
            r_remaining <= '0;
            r_q         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_q <= w_next_q;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode      <= mode;
                        r_remaining <= w_count_m1;
                        if (w_count_m1 != '0) begin
                            r_state <= S_BURST;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_done <= 1'b0;
                    end
                end
                S_BURST: begin
                    r_remaining <= r_remaining - CNT_WIDTH'(1);
                    if (r_remaining == CNT_WIDTH'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;
    assign SRSO = r_q[DATA_WIDTH-1];
    assign SLSO = r_q[0];

endmodule

// File: tb/tb_shift_reg_universal_n.sv
// Bench for shift_reg_universal_n: directed scenario tasks plus a randomized
// run checked against an arithmetic reference model of the register.
module tb_shift_reg_universal_n;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [2:0]    mode;
    logic [DW-1:0] p;
    logic          SRSI, SLSI, start;
    logic [CW-1:0] shift_count;
    logic [DW-1:0] q;
    logic          SRSO, SLSO, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int unsigned mq;
    int unsigned mleft;
    int unsigned mmode;
    bit          mbusy, mdone;
    bit          ever_done;

    shift_reg_universal_n #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Reset(Reset), .mode(mode), .p(p),
        .SRSI(SRSI), .SLSI(SLSI), .start(start),
        .shift_count(shift_count), .q(q), .SRSO(SRSO),
        .SLSO(SLSO), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    function automatic int unsigned op(int unsigned m, int unsigned v);
        int unsigned full = 1 << DW;
        int unsigned half = full / 2;
        case (m)
            1: return (v * 2 + SRSI) % full;
            2: return v / 2 + (SLSI ? half : 0);
            3: return p;
            4: return (v * 2) % full + v / half;
            5: return v / 2 + (v % 2) * half;
            6: return v / 2 + (v >= half ? half : 0);
            default: return v;
        endcase
    endfunction

    task automatic model_step();
        if (Reset) begin
            mq = 0; mleft = 0; mmode = 0; mbusy = 0; mdone = 0;
        end else if (mleft > 0) begin
            mq = op(mmode, mq);
            mleft--;
            mbusy = (mleft > 0);
            mdone = (mleft == 0);
        end else begin
            mq = op(mode, mq);
            if (start && shift_count != 0 && mode inside {1, 2, 4, 5, 6}) begin
                mmode = mode;
                mleft = shift_count - 1;
                mbusy = (mleft > 0);
                mdone = (mleft == 0);
            end else begin
                mdone = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        if (done === 1'b1) ever_done = 1;
    endtask

    task automatic drive(bit r, int m, int pv, bit sr, bit sl, bit st, int c);
        Reset = r; mode = 3'(m); p = DW'(pv);
        SRSI = sr; SLSI = sl; start = st; shift_count = CW'(c);
    endtask

    task automatic load(int v);
        drive(0, 3, v, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 3, 'hA5, 0, 0, 0, 0);
        tick();
        n_checks += 3;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        tick(); tick();
        n_checks++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_hold_q got=%h exp=00", q); end
    endtask

    task automatic test_modes();
        load('hA5);
        n_checks++;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL load got=%h exp=a5", q); end
        drive(0, 1, 0, 1, 0, 0, 0); tick();
        n_checks += 3;
        if (q !== 8'h4B) begin n_fail++; $display("FAIL shl got=%h exp=4b", q); end
        if (SRSO !== 1'b0) begin n_fail++; $display("FAIL srso got=%b exp=0", SRSO); end
        if (SLSO !== 1'b1) begin n_fail++; $display("FAIL slso got=%b exp=1", SLSO); end
        drive(0, 2, 0, 1, 0, 0, 0); tick();
        n_checks++;
        if (q !== 8'h25) begin n_fail++; $display("FAIL shr got=%h exp=25", q); end
        drive(0, 7, 'hFF, 1, 1, 0, 0); tick();
        n_checks++;
        if (q !== 8'h25) begin n_fail++; $display("FAIL reserved_hold got=%h exp=25", q); end
    endtask

    task automatic test_burst_rotate();
        logic [DW-1:0] exp_q [3];
        exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
        load('h81);
        drive(0, 4, 0, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            n_checks += 3;
            if (q !== exp_q[i]) begin n_fail++; $display("FAIL rol_q[%0d] got=%h exp=%h", i, q, exp_q[i]); end
            if (busy !== (i < 2)) begin n_fail++; $display("FAIL rol_busy[%0d] got=%b", i, busy); end
            if (done !== (i == 2)) begin n_fail++; $display("FAIL rol_done[%0d] got=%b", i, done); end
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rol_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_burst_asr();
        load('h90);
        drive(0, 6, 0, 0, 0, 1, 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        n_checks += 3;
        if (q !== 8'hF9) begin n_fail++; $display("FAIL asr4_q got=%h exp=f9", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL asr4_done got=%b exp=1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL asr4_busy got=%b exp=0", busy); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL asr4_pulse got=%b exp=0", done); end
        drive(0, 6, 0, 0, 0, 1, 1); tick();
        n_checks += 3;
        if (q !== 8'hFC) begin n_fail++; $display("FAIL asr1_q got=%h exp=fc", q); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL asr1_busy got=%b exp=0", busy); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL asr1_done got=%b exp=1", done); end
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL asr1_pulse got=%b exp=0", done); end
    endtask

    task automatic test_ignore();
        load('h01);
        drive(0, 5, 0, 0, 0, 1, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(0, $urandom_range(0, 7), $urandom, 0, 0,
                  $urandom_range(0, 1), $urandom_range(0, 15));
            n_checks++;
            if (busy !== (i < 4)) begin n_fail++; $display("FAIL ign_busy[%0d] got=%b", i, busy); end
        end
        n_checks += 2;
        if (q !== 8'h08) begin n_fail++; $display("FAIL ign_q got=%h exp=08", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done got=%b exp=1", done); end
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cnt0_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL cnt0_done got=%b exp=0", done); end
        if (q !== 8'h08) begin n_fail++; $display("FAIL cnt0_q got=%h exp=08", q); end
        drive(0, 3, 'h5A, 0, 0, 1, 3); tick();
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ldst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL ldst_done got=%b exp=0", done); end
        if (q !== 8'h5A) begin n_fail++; $display("FAIL ldst_q got=%h exp=5a", q); end
    endtask

    task automatic test_reset_abort();
        load('h55);
        drive(0, 1, 0, 0, 0, 1, 8);
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got=%b exp=1", busy); end
        ever_done = 0;
        drive(1, 1, 0, 0, 0, 1, 8); tick();
        n_checks += 2;
        if (q !== 8'h00) begin n_fail++; $display("FAIL abort_q got=%h exp=00", q); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy2 got=%b exp=0", busy); end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (ever_done) begin n_fail++; $display("FAIL abort_done got=1 exp=0"); end
        drive(0, 1, 0, 1, 0, 1, 2); tick();
        drive(0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b exp=1", busy); end
        tick();
        n_checks += 2;
        if (q !== 8'h03) begin n_fail++; $display("FAIL restart_q got=%h exp=03", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done got=%b exp=1", done); end
    endtask

    task automatic test_back_to_back();
        load('h0F);
        drive(0, 4, 0, 0, 0, 1, 2); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        drive(0, 4, 0, 0, 0, 1, 3); tick();
        n_checks += 3;
        if (q !== 8'h78) begin n_fail++; $display("FAIL b2b_q got=%h exp=78", q); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done got=%b exp=0", done); end
        drive(0, 5, 0, 0, 0, 1, 1); tick(); tick();
        n_checks += 2;
        if (q !== 8'hE1) begin n_fail++; $display("FAIL b2b_q2 got=%h exp=e1", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got=%b exp=1", done); end
        tick();
        n_checks += 3;
        if (q !== 8'hF0) begin n_fail++; $display("FAIL b2b_cnt1_q got=%h exp=f0", q); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_cnt1_done got=%b exp=1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt1_busy got=%b exp=0", busy); end
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_end_done got=%b exp=0", done); end
    endtask

    task automatic test_random();
        int m, c;
        bit st;
        for (int i = 0; i < 600; i++) begin
            m  = $urandom_range(0, 7);
            st = ($urandom_range(0, 3) == 0);
            c  = $urandom_range(0, 15);
            // count-0 starts only with non-shift modes
            if (st && c == 0 && m inside {1, 2, 4, 5, 6}) m = 3;
            drive($urandom_range(0, 79) == 0, m, $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), st, c);
            tick();
            n_checks += 5;
            if (q !== DW'(mq)) begin n_fail++; $display("FAIL rnd_q[%0d] got=%h exp=%h", i, q, mq); end
            if (busy !== mbusy) begin n_fail++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, busy, mbusy); end
            if (done !== mdone) begin n_fail++; $display("FAIL rnd_done[%0d] got=%b exp=%b", i, done, mdone); end
            if (SRSO !== mq[DW-1]) begin n_fail++; $display("FAIL rnd_srso[%0d] got=%b", i, SRSO); end
            if (SLSO !== mq[0]) begin n_fail++; $display("FAIL rnd_slso[%0d] got=%b", i, SLSO); end
        end
    endtask

    initial begin
        mq = 0; mleft = 0; mmode = 0; mbusy = 0; mdone = 0; ever_done = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        test_reset();
        test_modes();
        test_burst_rotate();
        test_burst_asr();
        test_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
